// File: rtl/kb_ps2_rx.sv
// rtl/kb_ps2_rx.sv - PS/2 keyboard frame receiver with scan-code FIFO and CPU register port
module kb_ps2_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       a0,
    input  logic       n_kb_oe,
    input  logic       kb_cp,
    output logic [7:0] d_out,
    output logic       d_oe,
    output logic       kb_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync, cp_sync;
    logic          clk_prev, cp_prev;
    logic          fall, strobe, bit_in;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] tmo_cnt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          empty, full;
    logic          ovf, ferr;
    logic          frame_end, frame_good, push, pop, clr, ferr_set;

    // Synchronisers idle high so reset never fabricates an edge or strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            cp_sync   <= 2'b11;
            clk_prev  <= 1'b1;
            cp_prev   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            cp_sync   <= {cp_sync[0], kb_cp};
            clk_prev  <= clk_sync[1];
            cp_prev   <= cp_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign strobe = ~cp_prev & cp_sync[1];
    assign bit_in = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
        end else begin
            if (fall)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (fall && !bit_in) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                DATA: begin
                    if (fall) begin
                        shift_reg[bit_cnt] <= bit_in;
                        bit_cnt            <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                end
                PARITY: begin
                    if (fall) begin
                        parity_bit <= bit_in;
                        state      <= STOP;
                    end
                end
                STOP: begin
                    if (fall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A stalled keyboard abandons the partial frame without reporting it.
            if (state != IDLE && !fall && tmo_cnt == TMO_MAX)
                state <= IDLE;
        end
    end

    assign frame_end  = (state == STOP) && fall;
    assign frame_good = bit_in && (^{shift_reg, parity_bit});
    assign push       = frame_end && frame_good;
    assign ferr_set   = frame_end && !frame_good;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = strobe && !a0 && !empty;
    assign clr   = strobe && a0;

    always_ff @(posedge clk) begin
        if (push && (!full || pop))
            mem[wr_ptr[AW-1:0]] <= shift_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
            ferr   <= 1'b0;
        end else begin
            if (push && (!full || pop))
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Clear first so an error arriving in the same cycle wins.
            if (clr) begin
                ovf  <= 1'b0;
                ferr <= 1'b0;
            end
            if (push && full && !pop)
                ovf <= 1'b1;
            if (ferr_set)
                ferr <= 1'b1;
        end
    end

    assign kb_irq = !empty;
    assign d_oe   = ~n_kb_oe;

    always_comb begin
        d_out = 8'h00;
        if (!n_kb_oe) begin
            if (a0)
                d_out = {5'b0, ferr, ovf, !empty};
            else if (!empty)
                d_out = mem[rd_ptr[AW-1:0]];
        end
    end
endmodule
